// File: rtl/cc_miss_req_scheduler_if.sv
// rtl/cc_miss_req_scheduler_if.sv - miss request / FIFO push / AXI AR / fill-done bundle
//
// Purpose: groups every signal of cc_miss_req_scheduler except clk/rst_n.
// Ports (slave = scheduler side):
//   miss_req_valid_i/addr_i -> miss_req_ready_o     request handshake from tag compare
//   miss_addr_fifo_full_i -> miss_addr_fifo_wren_o/wdata_o   miss address FIFO push
//   mem_ar*_o / mem_arready_i                         AXI read address channel
//   fill_done_i                                       one line written to SRAM
//   outstanding_o, err_o                              status
interface cc_miss_req_scheduler_if #(
   parameter int CNT_W = 3
);
   logic             miss_req_valid_i;
   logic [31:0]      miss_req_addr_i;
   logic             miss_req_ready_o;
   logic             miss_addr_fifo_full_i;
   logic             miss_addr_fifo_wren_o;
   logic [31:0]      miss_addr_fifo_wdata_o;
   logic             mem_arvalid_o;
   logic             mem_arready_i;
   logic [31:0]      mem_araddr_o;
   logic [3:0]       mem_arlen_o;
   logic [2:0]       mem_arsize_o;
   logic [1:0]       mem_arburst_o;
   logic             fill_done_i;
   logic [CNT_W-1:0] outstanding_o;
   logic             err_o;

   modport slave (
      input  miss_req_valid_i, miss_req_addr_i, miss_addr_fifo_full_i,
             mem_arready_i, fill_done_i,
      output miss_req_ready_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
             mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
             outstanding_o, err_o
   );

   modport master (
      output miss_req_valid_i, miss_req_addr_i, miss_addr_fifo_full_i,
             mem_arready_i, fill_done_i,
      input  miss_req_ready_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
             mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
             outstanding_o, err_o
   );
endinterface

// File: rtl/cc_miss_req_scheduler.sv
// rtl/cc_miss_req_scheduler.sv - cache-miss line fill scheduler (FIFO push + AXI WRAP AR)
//
// Purpose: accepts one miss at a time, pushes its address to the miss address
// FIFO, issues an 8 x 64-bit critical-word-first WRAP burst, caps outstanding
// fills at MAX_OUTSTANDING and stalls misses to lines already in flight.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - cc_miss_req_scheduler_if.slave (request, FIFO push, AR channel,
//            fill_done, outstanding count, sticky error)
module cc_miss_req_scheduler #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   cc_miss_req_scheduler_if.slave     bus
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_AR_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   logic                  r_active;     // first clock edge after reset seen
   logic                  r_arvalid;
   logic [31:0]           r_araddr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_err;
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [25:0]           r_tag [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] r_tag_vld;

   logic                  w_line_hit;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_pop;
   logic [25:0]           w_req_tag;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign w_req_tag = bus.miss_req_addr_i[31:6];

   // Compared against the tracker before this cycle's pop, so a miss to the
   // line that completes this cycle waits one more cycle.
   always_comb begin
      w_line_hit = 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (r_tag_vld[i] && (r_tag[i] == w_req_tag)) begin
            w_line_hit = 1'b1;
         end
      end
   end

   assign w_ready  = r_active && (r_state == ST_IDLE)
                     && (r_count < CNT_W'(MAX_OUTSTANDING))
                     && !bus.miss_addr_fifo_full_i && !w_line_hit;
   assign w_accept = w_ready && bus.miss_req_valid_i;
   // A fill_done with nothing outstanding is an error, not a pop.
   assign w_pop    = bus.fill_done_i && (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_active  <= 1'b0;
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_count   <= '0;
         r_err     <= 1'b0;
         r_head    <= '0;
         r_tail    <= '0;
         r_tag_vld <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_active <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state   <= ST_AR_WAIT;
                  r_arvalid <= 1'b1;
                  r_araddr  <= {bus.miss_req_addr_i[31:3], 3'b000};
               end
            end
            ST_AR_WAIT: begin
               if (bus.mem_arready_i) begin
                  r_state   <= ST_IDLE;
                  r_arvalid <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_arvalid <= 1'b0;
            end
         endcase

         // Push and pop never touch the same slot: a push needs count < MAX,
         // a pop needs count > 0, so head == tail excludes doing both there.
         if (w_accept) begin
            r_tag[r_tail]     <= w_req_tag;
            r_tag_vld[r_tail] <= 1'b1;
            r_tail            <= f_next(r_tail);
         end
         if (w_pop) begin
            r_tag_vld[r_head] <= 1'b0;
            r_head            <= f_next(r_head);
         end

         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (bus.fill_done_i && (r_count == '0)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.miss_req_ready_o       = w_ready;
   assign bus.miss_addr_fifo_wren_o  = w_accept;
   assign bus.miss_addr_fifo_wdata_o = w_accept ? bus.miss_req_addr_i : 32'h0;
   assign bus.mem_arvalid_o          = r_arvalid;
   assign bus.mem_araddr_o           = r_araddr;
   assign bus.mem_arlen_o            = 4'd7;
   assign bus.mem_arsize_o           = 3'd3;
   assign bus.mem_arburst_o          = 2'b10;
   assign bus.outstanding_o          = r_count;
   assign bus.err_o                  = r_err;

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// tb/tb_cc_miss_req_scheduler.sv - directed table-driven bench for cc_miss_req_scheduler
module tb_cc_miss_req_scheduler;

   localparam int MAXO = 4;
   localparam int CW   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cc_miss_req_scheduler_if #(.CNT_W(CW)) bus();

   cc_miss_req_scheduler #(
      .MAX_OUTSTANDING (MAXO),
      .CNT_W           (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic        ar;
      logic        fd;
      logic        e_rdy;
      logic        e_wren;
      logic [31:0] e_wd;
      logic        e_arv;
      logic [31:0] e_araddr;
      logic [2:0]  e_out;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic v, logic [31:0] a, logic ar, logic fd,
                               logic rdy, logic wren, logic [31:0] wd,
                               logic arv, logic [31:0] araddr, logic [2:0] out,
                               logic err);
      vec_t t;
      t.v = v; t.a = a; t.ar = ar; t.fd = fd;
      t.e_rdy = rdy; t.e_wren = wren; t.e_wd = wd; t.e_arv = arv;
      t.e_araddr = araddr; t.e_out = out; t.e_err = err;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic fu,
                        input logic ar, input logic fd);
      bus.miss_req_valid_i      = v;
      bus.miss_req_addr_i       = a;
      bus.miss_addr_fifo_full_i = fu;
      bus.mem_arready_i         = ar;
      bus.fill_done_i           = fd;
   endtask

   task automatic check_all(input string tg, input logic rdy, input logic wren,
                            input logic [31:0] wd, input logic arv,
                            input logic [31:0] araddr, input logic [2:0] out,
                            input logic err);
      chk({tg, ".ready"},   32'(bus.miss_req_ready_o),      32'(rdy));
      chk({tg, ".wren"},    32'(bus.miss_addr_fifo_wren_o), 32'(wren));
      chk({tg, ".wdata"},   bus.miss_addr_fifo_wdata_o,     wd);
      chk({tg, ".arvalid"}, 32'(bus.mem_arvalid_o),         32'(arv));
      chk({tg, ".araddr"},  bus.mem_araddr_o,               araddr);
      chk({tg, ".out"},     32'(bus.outstanding_o),         32'(out));
      chk({tg, ".err"},     32'(bus.err_o),                 32'(err));
      chk({tg, ".arlen"},   32'(bus.mem_arlen_o),           32'd7);
      chk({tg, ".arsize"},  32'(bus.mem_arsize_o),          32'd3);
      chk({tg, ".arburst"}, 32'(bus.mem_arburst_o),         32'd2);
   endtask

   initial begin
      //              v  addr         ar fd  rdy wren wdata        arv araddr       out err
      // single miss
      vecs.push_back(mk(1, 32'h0000_1238, 0, 0, 1, 1, 32'h0000_1238, 0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0000_1238, 1, 0));
      vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_1238, 1, 0));
      vecs.push_back(mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 32'h0000_1238, 1, 0));
      vecs.push_back(mk(0, 32'h0,         0, 0, 1, 0, 32'h0,         0, 32'h0000_1238, 0, 0));
      // same-line stall, released one cycle after fill_done; next line not stalled
      vecs.push_back(mk(1, 32'h0000_1200, 0, 0, 1, 1, 32'h0000_1200, 0, 32'h0000_1238, 0, 0));
      vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_1200, 1, 0));
      vecs.push_back(mk(1, 32'h0000_1238, 0, 0, 0, 0, 32'h0,         0, 32'h0000_1200, 1, 0));
      vecs.push_back(mk(1, 32'h0000_1238, 0, 1, 0, 0, 32'h0,         0, 32'h0000_1200, 1, 0));
      vecs.push_back(mk(1, 32'h0000_1238, 0, 0, 1, 1, 32'h0000_1238, 0, 32'h0000_1200, 0, 0));
      vecs.push_back(mk(1, 32'h0000_1240, 1, 0, 0, 0, 32'h0,         1, 32'h0000_1238, 1, 0));
      vecs.push_back(mk(1, 32'h0000_1240, 0, 0, 1, 1, 32'h0000_1240, 0, 32'h0000_1238, 1, 0));
      vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_1240, 2, 0));
      // accept and fill_done together at outstanding 2
      vecs.push_back(mk(1, 32'h0000_2000, 0, 1, 1, 1, 32'h0000_2000, 0, 32'h0000_1240, 2, 0));
      vecs.push_back(mk(1, 32'h0000_1200, 1, 0, 0, 0, 32'h0,         1, 32'h0000_2000, 2, 0));
      vecs.push_back(mk(1, 32'h0000_1210, 0, 0, 1, 1, 32'h0000_1210, 0, 32'h0000_2000, 2, 0));
      vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_1210, 3, 0));
      vecs.push_back(mk(1, 32'h0000_2008, 0, 0, 0, 0, 32'h0,         0, 32'h0000_1210, 3, 0));
      // outstanding limit
      vecs.push_back(mk(1, 32'h0000_3000, 0, 0, 1, 1, 32'h0000_3000, 0, 32'h0000_1210, 3, 0));
      vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_3000, 4, 0));
      vecs.push_back(mk(1, 32'h0000_4000, 0, 0, 0, 0, 32'h0,         0, 32'h0000_3000, 4, 0));
      vecs.push_back(mk(1, 32'h0000_4000, 0, 1, 0, 0, 32'h0,         0, 32'h0000_3000, 4, 0));
      vecs.push_back(mk(1, 32'h0000_4000, 0, 0, 1, 1, 32'h0000_4000, 0, 32'h0000_3000, 3, 0));
      vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_4000, 4, 0));
      // drain
      vecs.push_back(mk(0, 32'h0,         0, 1, 0, 0, 32'h0,         0, 32'h0000_4000, 4, 0));
      vecs.push_back(mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 32'h0000_4000, 3, 0));
      vecs.push_back(mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 32'h0000_4000, 2, 0));
      vecs.push_back(mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 32'h0000_4000, 1, 0));
      vecs.push_back(mk(0, 32'h0,         0, 0, 1, 0, 32'h0,         0, 32'h0000_4000, 0, 0));
      // fill_done at count 0 -> sticky error
      vecs.push_back(mk(0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 32'h0000_4000, 0, 0));
      vecs.push_back(mk(0, 32'h0,         0, 0, 1, 0, 32'h0,         0, 32'h0000_4000, 0, 1));
      vecs.push_back(mk(0, 32'h0,         0, 0, 1, 0, 32'h0,         0, 32'h0000_4000, 0, 1));

      // reset state, with a request already presented
      drive(1, 32'h0000_1238, 0, 0, 0);
      #3;
      check_all("reset", 0, 0, 32'h0, 0, 32'h0, 0, 0);

      // release mid-cycle: nothing accepted until the next rising edge
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all("release", 0, 0, 32'h0, 0, 32'h0, 0, 0);
      drive(0, 32'h0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].a, 1'b0, vecs[i].ar, vecs[i].fd);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_wren, vecs[i].e_wd,
                   vecs[i].e_arv, vecs[i].e_araddr, vecs[i].e_out, vecs[i].e_err);
      end

      // FIFO full blocks acceptance with valid held
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1, 32'h0000_503C, 1, 0, 0);
         #1;
         check_all($sformatf("bp_full%0d", k), 0, 0, 32'h0, 0, 32'h0000_4000, 0, 1);
      end
      @(negedge clk);
      drive(1, 32'h0000_503C, 0, 0, 0);
      #1;
      check_all("bp_acc", 1, 1, 32'h0000_503C, 0, 32'h0000_4000, 0, 1);

      // arready low for 5 cycles; fill_done inside AR_WAIT pops the fill
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1, 32'h0000_6000, 0, 0, (k == 2));
         #1;
         check_all($sformatf("bp_wait%0d", k), 0, 0, 32'h0, 1, 32'h0000_5038,
                   (k <= 2) ? 3'd1 : 3'd0, 1);
      end

      // asynchronous reset in AR_WAIT
      @(negedge clk);
      drive(1, 32'h0000_6000, 0, 0, 0);
      #1;
      chk("pre_rst.arvalid", 32'(bus.mem_arvalid_o), 32'd1);
      chk("pre_rst.err",     32'(bus.err_o),         32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst_async", 0, 0, 32'h0, 0, 32'h0, 0, 0);

      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 32'h0000_7000, 0, 0, 0);
      #1;
      check_all("rst_rel", 0, 0, 32'h0, 0, 32'h0, 0, 0);
      @(negedge clk);
      #1;
      check_all("post_rst", 1, 1, 32'h0000_7000, 0, 32'h0, 0, 0);
      @(negedge clk);
      drive(0, 32'h0, 0, 1, 0);
      #1;
      check_all("post_rst_ar", 0, 0, 32'h0, 1, 32'h0000_7000, 1, 0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cc_miss_req_scheduler.md
Name: cc_miss_req_scheduler

Overview:
- Sequences cache-miss line fills between the tag-compare stage and memory.
- Accepts one miss request at a time and pushes its address into the miss address FIFO that the data fill unit pops.
- Issues the matching AXI AR burst (critical-word-first WRAP, 8 x 64-bit beats).
- Caps outstanding fills at MAX_OUTSTANDING and stalls any new miss to a line that is already in flight.

Parameters:
MAX_OUTSTANDING, 4, max fills issued but not yet written to SRAM (1..8)
CNT_W, 3, width of outstanding counter; must hold MAX_OUTSTANDING (CNT_W >= clog2(MAX_OUTSTANDING+1))

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
miss_req_valid_i  input  1  miss request from tag-compare stage
miss_req_addr_i  input  32  byte address of missing word
miss_req_ready_o  output  1  request accepted when valid & ready
miss_addr_fifo_full_i  input  1  miss address FIFO full
miss_addr_fifo_wren_o  output  1  FIFO push strobe
miss_addr_fifo_wdata_o  output  32  FIFO push data (= accepted miss_req_addr_i)
mem_arvalid_o  output  1  AXI AR valid
mem_arready_i  input  1  AXI AR ready
mem_araddr_o  output  32  {addr[31:3],3'b000}
mem_arlen_o  output  4  constant 4'd7
mem_arsize_o  output  3  constant 3'd3
mem_arburst_o  output  2  constant 2'b10 (WRAP)
fill_done_i  input  1  one-cycle pulse from fill unit: one line written to SRAM (fills complete in issue order)
outstanding_o  output  CNT_W  current outstanding count
err_o  output  1  sticky: fill_done_i received with count 0

Behaviour:
- Reset (async, rst_n low): state=IDLE; count=0; tracker entries invalid; err_o=0. Outputs miss_req_ready_o=0, fifo wren=0, arvalid=0, araddr=0, fifo wdata=0.
- Release of rst_n takes effect at the next rising clk edge.
- Reset mid-operation discards the pending AR and all tracked fills. No further fifo or AR activity occurs.
- FSM IDLE:
  - miss_req_ready_o = (count < MAX_OUTSTANDING) & !miss_addr_fifo_full_i & !line_hit. This is combinational.
  - line_hit = miss_req_addr_i[31:6] equals any valid tracker entry tag.
  - Accept (valid & ready) in the same cycle:
    - miss_addr_fifo_wren_o=1, wdata=miss_req_addr_i (combinational, single-cycle pulse).
    - Register the address; push addr[31:6] into the tracker tail; count+1.
    - Next state AR_WAIT.
- FSM AR_WAIT:
  - mem_arvalid_o=1; araddr comes from the registered address and stays stable until the handshake.
  - miss_req_ready_o=0.
  - On arready: next cycle arvalid=0, state IDLE.
  - Accept-to-arvalid latency is 1 cycle; minimum spacing between accepts is 2 cycles.
- Tracker:
  - In-order queue, depth MAX_OUTSTANDING, storing 26-bit line tags with per-entry valid bits.
  - fill_done_i pops the head and decrements count.
- Same-cycle accept and fill_done_i: count unchanged; push and pop both happen.
- line_hit is evaluated on pre-pop tracker state. A miss to the line finishing this cycle stalls one extra cycle.
- fill_done_i with count 0: no pop, count stays 0, err_o set until reset.
- fill_done_i is legal in any state, including AR_WAIT.
- miss_addr_fifo_full_i only gates acceptance; a push is never issued while full.
- count never exceeds MAX_OUTSTANDING; at the limit, ready is held 0 until a fill_done_i.
- Constant AR fields are driven at all times, including reset.

Test Plan:
- Single miss:
  - Stimulus: addr 0x0000_1238, arready high on the second cycle of AR_WAIT.
  - Required response: fifo wren pulse with wdata 0x0000_1238; araddr 0x0000_1238, arlen 7, arsize 3, arburst 2'b10; outstanding 1. After fill_done_i, outstanding 0.
- Same-line stall:
  - Stimulus: miss to 0x0000_1200 outstanding, then a request to 0x0000_1238.
  - Required response: ready=0 until fill_done_i; accepted one cycle after the pulse. A request to 0x0000_1240 (next line) is accepted immediately.
- Outstanding limit:
  - Stimulus: 4 misses to distinct lines with no fill_done_i.
  - Required response: the 5th request sees ready=0 and outstanding_o=4. One fill_done_i gives ready=1 on the next cycle.
- Simultaneous accept and fill_done_i:
  - Stimulus: outstanding=2.
  - Required response: outstanding stays 2; the tracker head is popped and the new tag is appended.
- Backpressure:
  - Stimulus: miss_addr_fifo_full_i=1 with valid held; then arready held low for 5 cycles after acceptance.
  - Required response: no wren while full. After acceptance, arvalid stays 1 and araddr stays stable all 5 cycles; no second accept occurs.
- Error and reset:
  - Stimulus: fill_done_i at count 0; then rst_n low asynchronously during AR_WAIT.
  - Required response: err_o=1 and sticky. Reset immediately drives arvalid=0, err_o=0, outstanding 0.
